kernel_nios2_qsys_0_oci_dct_packer: RTL and testbench
=====================================================

KERNEL_NIOS2_QSYS_0_OCI_DCT_PACKER -- requirements
Module: kernel_nios2_qsys_0_oci_dct_packer

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 64, idle cycles before a partial buffer auto-flushes (0 = auto-flush disabled).
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: trc_on  input  1  trace enable; codes ignored while low.
REQ-005 SHALL have port: code_valid  input  1  a 2-bit trace code is presented this cycle.
REQ-006 SHALL have port: code  input  2  trace code.
REQ-007 SHALL have port: flush  input  1  single-cycle request to emit the partial buffer.
REQ-008 SHALL have port: frame_ready  input  1  consumer accepts the frame.
REQ-009 SHALL have port: overflow_clr  input  1  clears the overflow flag.
REQ-010 SHALL have port: dct_buffer  output  30  live accumulation buffer, newest code in [1:0].
REQ-011 SHALL have port: dct_count  output  4  number of codes in dct_buffer, 0..14.
REQ-012 SHALL have port: frame_valid  output  1  output frame held.
REQ-013 SHALL have port: frame_data  output  30  emitted frame, right-aligned.
REQ-014 SHALL have port: frame_count  output  4  codes in frame_data, 1..15.
REQ-015 SHALL have port: overflow  output  1  sticky, a frame was dropped.
REQ-016 SHALL have port: drop_count  output  8  dropped-frame counter (see Configuration).

Function
REQ-017 Code accepted iff trc_on & code_valid; accept: dct_buffer <= {dct_buffer[27:0], code}, dct_count + 1.
REQ-018 Accept at dct_count==14 SHALL form a full frame {dct_buffer[27:0], code}, count 15, and clear dct_buffer/dct_count to 0 in the same cycle.
REQ-019 Flush (flush input, or timeout) with post-accept count>0 SHALL form a partial frame of the buffer (including a same-cycle accepted code), then clear buffer/count; flush with count 0 is a no-op.
REQ-020 Timeout counter SHALL reset on every accept and when dct_count==0; increments otherwise; reaching TIMEOUT-1 triggers a flush next edge; inactive when TIMEOUT==0.
REQ-021 Formed frame SHALL load frame_data/frame_count and set frame_valid the following cycle (1-cycle latency).
REQ-022 frame_valid/frame_data/frame_count SHALL hold stable until frame_valid & frame_ready; then frame_valid clears unless a new frame loads that same edge.
REQ-023 Frame formed while frame_valid & !frame_ready SHALL be dropped; held frame unchanged; overflow set.
REQ-024 overflow SHALL clear on overflow_clr; a simultaneous drop wins (overflow stays 1).
REQ-025 trc_on low SHALL retain buffer contents; flush and timeout still operate.
REQ-026 Code accept without a frame formed SHALL never alter the output register.

Reset
REQ-027 reset SHALL asynchronously clear dct_buffer, dct_count, timeout counter, frame_valid, frame_data, frame_count, overflow, drop_count to 0.
REQ-028 reset mid-accumulation SHALL discard the partial buffer with no frame emitted; first cycle after deassert is a normal cycle.

Configuration
REQ-029 Macro KERNEL_NIOS2_OCI_DCT_DROP_COUNT_EN defined: drop_count increments by 1 per dropped frame, saturates at 255, cleared by overflow_clr (drop same cycle gives 1).
REQ-030 Macro undefined: drop_count SHALL be tied to 0; all other behaviour identical.

Verification
REQ-031 Reset, trc_on=1, 15 consecutive codes 2'b01, frame_ready=1 -> one cycle after 15th: frame_valid=1, frame_data=30'h15555555, frame_count=15, dct_count=0.
REQ-032 3 codes 3,2,1 then flush pulse -> frame_data=30'h39, frame_count=3; flush with dct_count=0 -> no frame_valid.
REQ-033 TIMEOUT=4, one code 2'b10 then idle -> frame_count=1, frame_data=2 emitted at predicted cycle; TIMEOUT=0 -> nothing emitted after 1000 cycles.
REQ-034 frame_ready=0, form two full frames -> first frame held unchanged, overflow=1, drop_count=1 (macro on) / 0 (off); overflow_clr -> overflow=0.
REQ-035 Assert reset after 7 codes -> all outputs 0 immediately; after release 15 codes produce one correct frame_count=15 frame.
REQ-036 trc_on=0 with code_valid=1 for 20 cycles -> dct_count unchanged, no frame_valid.

Source files
------------

// File: rtl/kernel_nios2_qsys_0_oci_dct_packer.sv
// Trace-code packer: gathers 2-bit codes into 30-bit frames and emits full, flushed or timed-out frames.
// Optional macro KERNEL_NIOS2_OCI_DCT_DROP_COUNT_EN enables the saturating dropped-frame counter.
module kernel_nios2_qsys_0_oci_dct_packer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trc_on,
    input  logic        code_valid,
    input  logic [1:0]  code,
    input  logic        flush,
    input  logic        frame_ready,
    input  logic        overflow_clr,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        frame_valid,
    output logic [29:0] frame_data,
    output logic [3:0]  frame_count,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    localparam int unsigned TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TW-1:0] TMO_LAST_V = TW'(TMO_LAST);

    logic          accept;
    logic [29:0]   post_buf;
    logic [3:0]    post_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_flush;
    logic          form;
    logic          stall;
    logic          drop;
    logic          load;

    // post_buf/post_cnt already include a same-cycle accept, so they serve as
    // the frame contents for both the full case (count 15) and any flush.
    always_comb begin
        accept    = trc_on & code_valid;
        post_buf  = accept ? {dct_buffer[27:0], code} : dct_buffer;
        post_cnt  = dct_count + 4'(accept);
        tmo_flush = (TIMEOUT != 0) && (dct_count != '0) && (tmo_cnt == TMO_LAST_V);
        form      = (accept && (dct_count == 4'd14)) ||
                    ((flush || tmo_flush) && (post_cnt != '0));
        stall     = frame_valid & ~frame_ready;
        drop      = form & stall;
        load      = form & ~stall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dct_buffer <= '0;
            dct_count  <= '0;
        end else if (form) begin
            dct_buffer <= '0;
            dct_count  <= '0;
        end else if (accept) begin
            dct_buffer <= post_buf;
            dct_count  <= post_cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if ((TIMEOUT == 0) || accept || form || (dct_count == '0)) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_count <= '0;
        end else if (load) begin
            frame_valid <= 1'b1;
            frame_data  <= post_buf;
            frame_count <= post_cnt;
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef KERNEL_NIOS2_OCI_DCT_DROP_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (overflow_clr) begin
            drop_count <= drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_kernel_nios2_qsys_0_oci_dct_packer.sv
// Directed bench: one instance with TIMEOUT=4 and one with auto-flush disabled, sharing inputs.
module tb_kernel_nios2_qsys_0_oci_dct_packer;

    logic        clk;
    logic        reset;
    logic        trc_on;
    logic        code_valid;
    logic [1:0]  code;
    logic        flush;
    logic        frame_ready;
    logic        overflow_clr;

    logic [29:0] dct_buffer,  dct_buffer_z;
    logic [3:0]  dct_count,   dct_count_z;
    logic        frame_valid, frame_valid_z;
    logic [29:0] frame_data,  frame_data_z;
    logic [3:0]  frame_count, frame_count_z;
    logic        overflow,    overflow_z;
    logic [7:0]  drop_count,  drop_count_z;

    int checks   = 0;
    int failures = 0;

`ifdef KERNEL_NIOS2_OCI_DCT_DROP_COUNT_EN
    localparam logic [7:0] DROP_EXP = 8'd1;
`else
    localparam logic [7:0] DROP_EXP = 8'd0;
`endif

    kernel_nios2_qsys_0_oci_dct_packer #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .trc_on(trc_on), .code_valid(code_valid), .code(code),
        .flush(flush), .frame_ready(frame_ready), .overflow_clr(overflow_clr),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .frame_valid(frame_valid),
        .frame_data(frame_data), .frame_count(frame_count), .overflow(overflow),
        .drop_count(drop_count)
    );

    kernel_nios2_qsys_0_oci_dct_packer #(.TIMEOUT(0)) dut_z (
        .clk(clk), .reset(reset), .trc_on(trc_on), .code_valid(code_valid), .code(code),
        .flush(flush), .frame_ready(frame_ready), .overflow_clr(overflow_clr),
        .dct_buffer(dct_buffer_z), .dct_count(dct_count_z), .frame_valid(frame_valid_z),
        .frame_data(frame_data_z), .frame_count(frame_count_z), .overflow(overflow_z),
        .drop_count(drop_count_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; trc_on = 1'b1; code_valid = 1'b0; code = 2'b00;
        flush = 1'b0; frame_ready = 1'b1; overflow_clr = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; trc_on = 1'b0; code_valid = 1'b0; code = 2'b00;
        flush = 1'b0; frame_ready = 1'b0; overflow_clr = 1'b0;
        tick();
        checks++;
        if ({dct_buffer, dct_count, frame_valid, frame_data, frame_count, overflow, drop_count} !== '0) begin
            failures++;
            $display("FAIL reset_state dut: buf=%h cnt=%0d fv=%b fd=%h fc=%0d ov=%b dc=%0d expected all zero",
                     dct_buffer, dct_count, frame_valid, frame_data, frame_count, overflow, drop_count);
        end
        checks++;
        if ({dct_buffer_z, dct_count_z, frame_valid_z, frame_data_z, frame_count_z, overflow_z, drop_count_z} !== '0) begin
            failures++;
            $display("FAIL reset_state dut_z: buf=%h cnt=%0d fv=%b expected all zero",
                     dct_buffer_z, dct_count_z, frame_valid_z);
        end
        reset = 1'b0;
    endtask

    task automatic test_full_frame();
        do_reset();
        code_valid = 1'b1; code = 2'b01;
        repeat (14) tick();
        checks++;
        if (dct_count !== 4'd14 || dct_buffer !== 30'h05555555 || frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_14codes: cnt=%0d buf=%h fv=%b expected 14 05555555 0", dct_count, dct_buffer, frame_valid);
        end
        tick();
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h15555555 || frame_count !== 4'd15 || dct_count !== 4'd0) begin
            failures++;
            $display("FAIL full_frame: fv=%b fd=%h fc=%0d cnt=%0d expected 1 15555555 15 0",
                     frame_valid, frame_data, frame_count, dct_count);
        end
        code_valid = 1'b0;
        tick();
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_consumed: fv=%b expected 0", frame_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        code_valid = 1'b1;
        code = 2'd3; tick();
        code = 2'd2; tick();
        code = 2'd1; tick();
        code_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h39 || frame_count !== 4'd3 || dct_count !== 4'd0) begin
            failures++;
            $display("FAIL flush_partial: fv=%b fd=%h fc=%0d cnt=%0d expected 1 39 3 0",
                     frame_valid, frame_data, frame_count, dct_count);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_empty: fv=%b fc=%0d expected fv 0", frame_valid, frame_count);
        end
        code_valid = 1'b1; code = 2'd2; flush = 1'b1;
        tick();
        code_valid = 1'b0; flush = 1'b0;
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h2 || frame_count !== 4'd1 || dct_count !== 4'd0) begin
            failures++;
            $display("FAIL flush_same_cycle: fv=%b fd=%h fc=%0d cnt=%0d expected 1 2 1 0",
                     frame_valid, frame_data, frame_count, dct_count);
        end
    endtask

    task automatic test_timeout();
        logic seen;
        do_reset();
        code_valid = 1'b1; code = 2'd2;
        tick();
        code_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (frame_valid !== 1'b0 || dct_count !== 4'd1) begin
                failures++;
                $display("FAIL timeout_early cycle %0d: fv=%b cnt=%0d expected 0 1", i, frame_valid, dct_count);
            end
        end
        tick();
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h2 || frame_count !== 4'd1 || dct_count !== 4'd0) begin
            failures++;
            $display("FAIL timeout_flush: fv=%b fd=%h fc=%0d cnt=%0d expected 1 2 1 0",
                     frame_valid, frame_data, frame_count, dct_count);
        end
        seen = 1'b0;
        repeat (1000) begin
            tick();
            if (frame_valid_z === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || dct_count_z !== 4'd1 || dct_buffer_z !== 30'h2) begin
            failures++;
            $display("FAIL timeout_disabled: seen_fv=%b cnt=%0d buf=%h expected 0 1 2", seen, dct_count_z, dct_buffer_z);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        frame_ready = 1'b0;
        code_valid = 1'b1; code = 2'b01;
        repeat (15) tick();
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h15555555 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_first_frame: fv=%b fd=%h ov=%b expected 1 15555555 0", frame_valid, frame_data, overflow);
        end
        code = 2'b10;
        repeat (15) tick();
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h15555555 || frame_count !== 4'd15 || dct_count !== 4'd0) begin
            failures++;
            $display("FAIL ovf_held: fv=%b fd=%h fc=%0d cnt=%0d expected 1 15555555 15 0",
                     frame_valid, frame_data, frame_count, dct_count);
        end
        checks++;
        if (overflow !== 1'b1 || drop_count !== DROP_EXP) begin
            failures++;
            $display("FAIL ovf_flag: ov=%b dc=%0d expected 1 %0d", overflow, drop_count, DROP_EXP);
        end
        code_valid = 1'b0; overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0 || drop_count !== 8'd0 || frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL ovf_clear: ov=%b dc=%0d fv=%b expected 0 0 1", overflow, drop_count, frame_valid);
        end
        code_valid = 1'b1; code = 2'b11;
        repeat (14) tick();
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0; code_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || drop_count !== DROP_EXP || frame_data !== 30'h15555555) begin
            failures++;
            $display("FAIL ovf_drop_beats_clr: ov=%b dc=%0d fd=%h expected 1 %0d 15555555",
                     overflow, drop_count, frame_data, DROP_EXP);
        end
        frame_ready = 1'b1;
        tick();
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_release: fv=%b expected 0", frame_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        frame_ready = 1'b0;
        code_valid = 1'b1; code = 2'd3; flush = 1'b1;
        tick();
        flush = 1'b0; code = 2'b01;
        repeat (7) tick();
        code_valid = 1'b0;
        checks++;
        if (dct_count !== 4'd7 || frame_valid !== 1'b1 || frame_data !== 30'h3) begin
            failures++;
            $display("FAIL mid_setup: cnt=%0d fv=%b fd=%h expected 7 1 3", dct_count, frame_valid, frame_data);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({dct_buffer, dct_count, frame_valid, frame_data, frame_count, overflow, drop_count} !== '0) begin
            failures++;
            $display("FAIL mid_async_reset: buf=%h cnt=%0d fv=%b fd=%h fc=%0d expected all zero",
                     dct_buffer, dct_count, frame_valid, frame_data, frame_count);
        end
        @(negedge clk);
        reset = 1'b0;
        frame_ready = 1'b1; code_valid = 1'b1; code = 2'b11;
        repeat (14) tick();
        checks++;
        if (frame_valid !== 1'b0 || dct_count !== 4'd14) begin
            failures++;
            $display("FAIL mid_refill: fv=%b cnt=%0d expected 0 14", frame_valid, dct_count);
        end
        tick();
        code_valid = 1'b0;
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h3FFFFFFF || frame_count !== 4'd15) begin
            failures++;
            $display("FAIL mid_frame: fv=%b fd=%h fc=%0d expected 1 3fffffff 15", frame_valid, frame_data, frame_count);
        end
    endtask

    task automatic test_trc_off();
        logic seen;
        do_reset();
        code_valid = 1'b1;
        code = 2'b01; tick();
        code = 2'b10; tick();
        trc_on = 1'b0; code = 2'b11;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (frame_valid_z === 1'b1) seen = 1'b1;
        end
        checks++;
        if (dct_count_z !== 4'd2 || dct_buffer_z !== 30'h6 || seen !== 1'b0) begin
            failures++;
            $display("FAIL trc_off_hold: cnt=%0d buf=%h seen_fv=%b expected 2 6 0", dct_count_z, dct_buffer_z, seen);
        end
        checks++;
        if (dct_count !== 4'd0) begin
            failures++;
            $display("FAIL trc_off_timeout: cnt=%0d expected 0", dct_count);
        end
        code_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (frame_valid_z !== 1'b1 || frame_data_z !== 30'h6 || frame_count_z !== 4'd2) begin
            failures++;
            $display("FAIL trc_off_flush: fv=%b fd=%h fc=%0d expected 1 6 2", frame_valid_z, frame_data_z, frame_count_z);
        end
        trc_on = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flush();
        test_timeout();
        test_overflow();
        test_reset_mid();
        test_trc_off();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
